// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one halfword flash read engine between the boot loader
// (port 0) and the CPU data bus (port 1). Each 32-bit request becomes two
// halfword reads (low half first) with a gap cycle between them. Arbitration is
// round-robin on ties, and every wait state has a timeout that aborts the
// request with err=1 and all-ones data.
`timescale 1ns/1ps
module flash_arbiter #(
  parameter int WADDR_W = 21,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WADDR_W-1:0] addr0,
  output logic               ack0,
  input  logic               req1,
  input  logic [WADDR_W-1:0] addr1,
  output logic               ack1,
  output logic [31:0]        rdata,
  output logic               err,
  output logic               busy,
  output logic               eng_req,
  output logic [WADDR_W:0]   eng_addr,
  input  logic [15:0]        eng_data,
  input  logic               eng_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LO_WAIT, GAP, HI_WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [WADDR_W-1:0] waddr;
  logic               id;
  logic               last_grant;
  logic [CW-1:0]      cnt;
  logic               gnt;
  logic               expired;

  // Counter value TIMEOUT-1 means this is the TIMEOUT-th cycle in the wait
  // state; a ready in that same cycle still wins because it is checked first.
  assign expired = (cnt == CW'(TIMEOUT - 1));

  // Next-state, arbitration choice and decoded outputs.
  always_comb begin
    state_nxt = state;
    gnt       = (req0 && req1) ? ~last_grant : req1;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state != IDLE);
    eng_req   = 1'b0;
    eng_addr  = {waddr, 1'b0};
    case (state)
      IDLE:    if (req0 || req1) state_nxt = LO_WAIT;
      LO_WAIT: begin
        eng_req = 1'b1;
        if (eng_ready)    state_nxt = GAP;
        else if (expired) state_nxt = RESP;
      end
      GAP:     state_nxt = HI_WAIT;
      HI_WAIT: begin
        eng_req  = 1'b1;
        eng_addr = {waddr, 1'b1};
        if (eng_ready || expired) state_nxt = RESP;
      end
      RESP: begin
        ack0      = ~id;
        ack1      = id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, grant latch, timeout counter and read-data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      waddr      <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter restarts whenever the state changes, so each wait state
      // gets its own full budget.
      if (state_nxt != state) cnt <= '0;
      else if (state == LO_WAIT || state == HI_WAIT) cnt <= cnt + CW'(1);
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (req0 || req1) begin
            waddr <= gnt ? addr1 : addr0;
            id    <= gnt;
            // Only a real tie moves the round-robin pointer.
            if (req0 && req1) last_grant <= gnt;
          end
        end
        LO_WAIT: begin
          if (eng_ready) rdata[15:0] <= eng_data;
          else if (expired) begin
            rdata <= 32'hFFFF_FFFF;
            err   <= 1'b1;
          end
        end
        HI_WAIT: begin
          if (eng_ready) rdata[31:16] <= eng_data;
          else if (expired) begin
            rdata <= 32'hFFFF_FFFF;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: a transaction-level model predicts
// grant order, ack timing, returned data and error for each request against a
// latency-programmable engine model backed by a small flash array.
`timescale 1ns/1ps
module tb_flash_arbiter;
  localparam int WADDR_W = 21;
  localparam int TIMEOUT = 63;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req0 = 1'b0, req1 = 1'b0;
  logic [WADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic               ack0, ack1, err, busy, eng_req;
  logic [31:0]        rdata;
  logic [WADDR_W:0]   eng_addr;
  logic [15:0]        eng_data = '0;
  logic               eng_ready = 1'b0;

  flash_arbiter #(.WADDR_W(WADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .err(err), .busy(busy),
    .eng_req(eng_req), .eng_addr(eng_addr),
    .eng_data(eng_data), .eng_ready(eng_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [15:0] mem [1024];
  int lat_lo = 3, lat_hi = 3;   // 0 = engine never readies
  bit stale_en = 1'b0;
  int run_cnt = 0, eng_lat = 0;
  int model_last = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Engine model: readies on the Nth consecutive eng_req cycle of a read,
  // optionally fires a stray ready while the arbiter is busy without a request.
  always @(negedge clk) begin
    if (eng_req) begin
      run_cnt   = run_cnt + 1;
      eng_lat   = eng_addr[0] ? lat_hi : lat_lo;
      eng_ready = (eng_lat != 0) && (run_cnt == eng_lat);
      eng_data  = eng_ready ? mem[eng_addr[9:0]] : 16'($urandom);
    end else begin
      run_cnt   = 0;
      eng_ready = stale_en && busy;
      eng_data  = 16'hDEAD;
    end
  end

  function automatic bit is_to(input int l);
    return (l == 0) || (l > TIMEOUT);
  endfunction

  function automatic int eff(input int l);
    return is_to(l) ? TIMEOUT : l;
  endfunction

  function automatic int pick_lat();
    int r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return TIMEOUT;
    if (r == 2) return TIMEOUT + 1;
    return $urandom_range(1, 5);
  endfunction

  task automatic start(input int who, input logic [WADDR_W-1:0] a);
    if (who == 0) begin req0 = 1'b1; addr0 = a; end
    else          begin req1 = 1'b1; addr1 = a; end
  endtask

  // Serve one transaction for requester 'who' whose req is already high and
  // will be sampled by the next rising edge (cycle 0).
  task automatic serve(input int who, input logic [WADDR_W-1:0] a, input int llo,
                       input int lhi, input bit drop, input bit stale);
    int k = 0, nlo = 0, nhi = 0, exp_k, exp_lo, exp_hi;
    bit hi_ph = 0, seen = 0, done = 0, to_lo, to_any;
    logic [WADDR_W:0] ha_lo, ha_hi;
    logic [31:0] exp_d;
    lat_lo = llo; lat_hi = lhi; stale_en = stale;
    ha_lo  = {a, 1'b0};
    ha_hi  = {a, 1'b1};
    to_lo  = is_to(llo);
    to_any = to_lo || is_to(lhi);
    exp_lo = eff(llo);
    exp_hi = to_lo ? 0 : eff(lhi);
    exp_k  = to_lo ? exp_lo + 1 : exp_lo + exp_hi + 2;
    exp_d  = to_any ? 32'hFFFF_FFFF : {mem[ha_hi[9:0]], mem[ha_lo[9:0]]};
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
      if (eng_req) begin
        if (hi_ph) nhi++; else nlo++;
        chk("eng_addr", 64'(eng_addr), 64'({a, hi_ph}));
        seen = 1;
      end else if (seen) hi_ph = 1;
      chk("other_ack", 64'(who == 0 ? ack1 : ack0), 64'(0));
      if (drop && k == 2) begin
        if (who == 0) begin req0 = 1'b0; addr0 = 21'($urandom); end
        else          begin req1 = 1'b0; addr1 = 21'($urandom); end
      end
      if ((who == 0 ? ack0 : ack1) === 1'b1) begin
        done = 1;
        chk("ack_cycle", 64'(k), 64'(exp_k));
        chk("rdata", 64'(rdata), 64'(exp_d));
        chk("err", 64'(err), 64'(to_any));
        chk("lo_cycles", 64'(nlo), 64'(exp_lo));
        chk("hi_cycles", 64'(nhi), 64'(exp_hi));
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      end
    end
    if (!done) chk("ack_seen", 64'(0), 64'(1));
    stale_en = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_ack", 64'({ack0, ack1}), 64'(0));
  endtask

  // One arbitration round: the model picks the winner, the loser keeps its
  // request up and is served next as a lone requester.
  task automatic do_round(input bit r0, input bit r1);
    logic [WADDR_W-1:0] a0, a1;
    int win;
    a0 = 21'($urandom); a1 = 21'($urandom);
    if (r0) start(0, a0);
    if (r1) start(1, a1);
    if (r0 && r1) begin win = (model_last == 0) ? 1 : 0; model_last = win; end
    else win = r0 ? 0 : 1;
    serve(win, win ? a1 : a0, pick_lat(), pick_lat(), bit'($urandom_range(0, 3) == 0),
          bit'($urandom_range(0, 2) == 0));
    idle_check();
    if (r0 && r1) begin
      serve(1 - win, win ? a0 : a1, pick_lat(), pick_lat(), 1'b0,
            bit'($urandom_range(0, 2) == 0));
      idle_check();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[10'h100] = 16'h1234;
    mem[10'h101] = 16'hABCD;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_acks", 64'({ack0, ack1, err}), 64'(0));
    chk("rst_eng_req", 64'(eng_req), 64'(0));
    chk("rst_eng_addr", 64'(eng_addr), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    rst = 1'b0;

    // Plain read, engine latency 3: ack at cycle 8 with both halves.
    start(0, 21'h80);
    serve(0, 21'h80, 3, 3, 1'b0, 1'b0);
    idle_check();

    // Ties: first 0 then 1; second tie goes 1 then 0.
    do_round(1'b1, 1'b1);
    do_round(1'b1, 1'b1);

    // Timeouts in each half, and the TIMEOUT / TIMEOUT+1 boundary.
    start(0, 21'h12345); serve(0, 21'h12345, 0, 3, 1'b0, 1'b0); idle_check();
    start(1, 21'h00abc); serve(1, 21'h00abc, 2, 0, 1'b0, 1'b0); idle_check();
    start(0, 21'h00321); serve(0, 21'h00321, TIMEOUT, TIMEOUT, 1'b0, 1'b0); idle_check();
    start(1, 21'h1fffe); serve(1, 21'h1fffe, TIMEOUT + 1, 2, 1'b0, 1'b0); idle_check();

    // Stray ready during the gap must not be taken as the high half.
    start(0, 21'h00777); serve(0, 21'h00777, 2, 4, 1'b0, 1'b1); idle_check();

    // Requester drops its request mid-read; ack still arrives.
    start(1, 21'h00055); serve(1, 21'h00055, 3, 3, 1'b1, 1'b0); idle_check();

    // Reset during HI_WAIT aborts without an ack.
    lat_lo = 3; lat_hi = 3;
    start(0, 21'h00200);
    repeat (6) @(negedge clk);
    chk("pre_rst_eng_req", 64'(eng_req), 64'(1));
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_eng_req", 64'(eng_req), 64'(0));
    chk("midrst_ack", 64'(ack0), 64'(0));
    rst = 1'b0;
    model_last = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_ack", 64'({ack0, ack1}), 64'(0));
    end
    start(0, 21'h00201); serve(0, 21'h00201, 1, 5, 1'b0, 1'b0); idle_check();

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      int m = $urandom_range(1, 3);
      do_round(bit'(m[0]), bit'(m[1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
